// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO arbiter controller.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector. "last" names the producer granted most
// recently; on a tie the other producer wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Pick a single winner from the request vector.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Arbitrates two producers into one FIFO, issues consumer reads, tracks
// occupancy, supports a drain (flush) mode and keeps sticky error flags.
module fifo_arb_ctrl
  import fifo_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic             rd_req,
  output logic             rd_ack,
  input  logic             flush,
  input  logic             clr_err,
  output logic             fifo_write_en,
  output logic             fifo_read_en,
  output logic [WIDTH-1:0] fifo_data_in,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             ovf_err,
  output logic             udf_err
);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            last_q, last_d;
  logic            rd_ack_q, rd_ack_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic            run_s;
  logic            full_s;
  logic            empty_s;
  logic [1:0]      arb_gnt_s;
  logic [1:0]      gnt_s;
  logic            wr_s;
  logic            rd_s;
  logic            ovf_set_s;
  logic            udf_set_s;

  assign run_s   = (state_q == RUN);
  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});

  rr_arb2 u_rr_arb2 (
    .req  ({req1, req0}),
    .last (last_q),
    .gnt  (arb_gnt_s)
  );

  // Gate the arbiter result: grants only in RUN, with room, out of reset.
  always_comb begin
    gnt_s = 2'b00;
    if (!reset && run_s && !full_s) begin
      gnt_s = arb_gnt_s;
    end else begin
      gnt_s = 2'b00;
    end
  end

  assign wr_s = gnt_s[0] | gnt_s[1];

  // Read strobe: consumer-driven in RUN, self-driven drain in FLUSH.
  always_comb begin
    rd_s = 1'b0;
    if (reset) begin
      rd_s = 1'b0;
    end else if (run_s) begin
      rd_s = rd_req & ~empty_s;
    end else begin
      rd_s = ~empty_s;
    end
  end

  // Route the granted producer's data to the FIFO; zero when idle.
  always_comb begin
    fifo_data_in = {WIDTH{1'b0}};
    case (gnt_s)
      2'b01:   fifo_data_in = data0;
      2'b10:   fifo_data_in = data1;
      default: fifo_data_in = {WIDTH{1'b0}};
    endcase
  end

  // Next-state: mode, occupancy, round-robin pointer, ack and error flags.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = flush ? FLUSH : RUN;
      FLUSH:   state_d = empty_s ? RUN : FLUSH;
      default: state_d = RUN;
    endcase

    count_d = count_q;
    case ({wr_s, rd_s})
      2'b10: begin
        if (!full_s) begin
          count_d = count_q + CW'(1);
        end else begin
          count_d = count_q;
        end
      end
      2'b01: begin
        if (!empty_s) begin
          count_d = count_q - CW'(1);
        end else begin
          count_d = count_q;
        end
      end
      default: count_d = count_q;
    endcase

    last_d = last_q;
    case (gnt_s)
      2'b01:   last_d = 1'b0;
      2'b10:   last_d = 1'b1;
      default: last_d = last_q;
    endcase

    rd_ack_d = run_s & rd_s;

    ovf_set_s = run_s & (req0 | req1) & full_s;
    udf_set_s = run_s & rd_req & empty_s;

    // A new error event outranks a clear in the same cycle.
    ovf_d = ovf_q;
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    udf_d = udf_q;
    if (udf_set_s) begin
      udf_d = 1'b1;
    end else if (clr_err) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      count_q  <= {CW{1'b0}};
      last_q   <= 1'b0;
      rd_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      last_q   <= last_d;
      rd_ack_q <= rd_ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign gnt0          = gnt_s[0];
  assign gnt1          = gnt_s[1];
  assign fifo_write_en = wr_s;
  assign fifo_read_en  = rd_s;
  assign count         = count_q;
  assign full          = full_s;
  assign empty         = empty_s;
  assign busy          = (state_q == FLUSH);
  assign rd_ack        = rd_ack_q;
  assign ovf_err       = ovf_q;
  assign udf_err       = udf_q;

endmodule
